// File: rtl/mem_access_ctrl_if.sv
// Pipeline and data-memory signal bundle for mem_access_ctrl.
// slave = controller side, master = pipeline/memory side.
interface mem_access_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Result;
  logic [31:0] Val_Rm;
  logic [31:0] Mem_Read_Data;
  logic        Ready;
  logic        Freeze;
  logic        Error;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_data;
  logic        Mem_R_EN_o;
  logic        Mem_W_EN_o;
  logic [31:0] Mem_Data;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm, Mem_Data,
    output Mem_Read_Data, Ready, Freeze, Error,
           Mem_Address, Mem_Write_data, Mem_R_EN_o, Mem_W_EN_o
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Result, Val_Rm, Mem_Data,
    input  Mem_Read_Data, Ready, Freeze, Error,
           Mem_Address, Mem_Write_data, Mem_R_EN_o, Mem_W_EN_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller: IDLE -> ACCESS (WAIT_CYCLES) -> DONE.
// Optional MEM_RANGE_CHECK_EN adds out-of-window detection with Error reporting.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        req_s;
  logic        in_access_s;
  logic        last_s;
  logic        oor_s;

`ifdef MEM_RANGE_CHECK_EN
  logic        oor_q, oor_d;
  logic        err_q, err_d;
  assign oor_s = oor_q;
`else
  assign oor_s = 1'b0;
`endif

  assign req_s       = bus.MEM_R_EN | bus.MEM_W_EN;
  assign in_access_s = (state_q == S_ACCESS);
  assign last_s      = in_access_s && (cnt_q == 4'd0);

  // Next-state and datapath capture logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    oor_d   = oor_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          state_d = S_ACCESS;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          idx_d   = 8'((bus.ALU_Result - ADDR_BASE) >> 2);
          wdata_d = bus.Val_Rm;
          // Both enables high resolves to a write
          wr_d    = bus.MEM_W_EN;
`ifdef MEM_RANGE_CHECK_EN
          oor_d   = (bus.ALU_Result < ADDR_BASE) ||
                    (bus.ALU_Result >= (ADDR_BASE + 32'd1024));
          err_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          if (!wr_q) begin
            rdata_d = oor_s ? 32'd0 : bus.Mem_Data;
          end else begin
            rdata_d = rdata_q;
          end
`ifdef MEM_RANGE_CHECK_EN
          err_d   = oor_q;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 8'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.Freeze         = ((state_q == S_IDLE) && req_s) || in_access_s;
  assign bus.Ready          = ready_q;
  assign bus.Mem_Read_Data  = rdata_q;
  assign bus.Mem_Address    = in_access_s ? {24'd0, idx_q} : 32'd0;
  assign bus.Mem_Write_data = in_access_s ? wdata_q : 32'd0;
  assign bus.Mem_R_EN_o     = in_access_s && !wr_q;
  // Single write strobe in the final ACCESS cycle, suppressed when out of range
  assign bus.Mem_W_EN_o     = last_s && wr_q && !oor_s;
`ifdef MEM_RANGE_CHECK_EN
  assign bus.Error          = err_q;
`else
  assign bus.Error          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3),
// table-driven transactions with a scoreboard, plus reset and back-to-back sequences.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  mem_access_ctrl_if if1();
  mem_access_ctrl_if if3();

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  mem_access_ctrl #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  assign if1.Mem_Data = mem1[if1.Mem_Address[7:0]];
  assign if3.Mem_Data = mem3[if3.Mem_Address[7:0]];

  always @(posedge clk) begin
    if (if1.Mem_W_EN_o) mem1[if1.Mem_Address[7:0]] <= if1.Mem_Write_data;
    if (if3.Mem_W_EN_o) mem3[if3.Mem_Address[7:0]] <= if3.Mem_Write_data;
  end

  int sel;
  logic        ready_s, freeze_s, wen_s, ren_s, err_s;
  logic [31:0] maddr_s, mrd_s, mwd_s;
  assign ready_s  = (sel == 1) ? if3.Ready          : if1.Ready;
  assign freeze_s = (sel == 1) ? if3.Freeze         : if1.Freeze;
  assign wen_s    = (sel == 1) ? if3.Mem_W_EN_o     : if1.Mem_W_EN_o;
  assign ren_s    = (sel == 1) ? if3.Mem_R_EN_o     : if1.Mem_R_EN_o;
  assign err_s    = (sel == 1) ? if3.Error          : if1.Error;
  assign maddr_s  = (sel == 1) ? if3.Mem_Address    : if1.Mem_Address;
  assign mrd_s    = (sel == 1) ? if3.Mem_Read_Data  : if1.Mem_Read_Data;
  assign mwd_s    = (sel == 1) ? if3.Mem_Write_data : if1.Mem_Write_data;

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic        exp_err;
    int          exp_wcyc;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
    logic        err;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    if (sel == 1) begin
      if3.MEM_R_EN = rd; if3.MEM_W_EN = wr; if3.ALU_Result = addr; if3.Val_Rm = data;
    end else begin
      if1.MEM_R_EN = rd; if1.MEM_W_EN = wr; if1.ALU_Result = addr; if1.Val_Rm = data;
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"},  32'(ready_s), 32'd0);
    chk({tag, "_wen"},    32'(wen_s),   32'd0);
    chk({tag, "_ren"},    32'(ren_s),   32'd0);
    chk({tag, "_err"},    32'(err_s),   32'd0);
    chk({tag, "_maddr"},  maddr_s,      32'd0);
    chk({tag, "_mrd"},    mrd_s,        32'd0);
    chk({tag, "_mwd"},    mwd_s,        32'd0);
    chk({tag, "_freeze"}, 32'(freeze_s), 32'd0);
  endtask

  // Counts negedges from the request cycle until Ready; clears request after cycle 0
  task automatic wait_ready(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b0, 32'd0, 32'd0);
      if (ready_s) begin
        n  = c;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   wcnt;
    int   wcyc;
    bit   got;
    sel = v.sel;
    @(negedge clk);
    chk("ready_idle", 32'(ready_s), 32'd0);
    drive(v.rd, v.wr, v.addr, v.wdata);
    sb.push_back('{rdata: v.exp_rdata, cyc: v.exp_cyc, err: v.exp_err});
    #1 chk("freeze_c0", 32'(freeze_s), 32'd1);
    wcnt = 0; wcyc = 0; got = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        chk("mem_addr", maddr_s, v.exp_addr);
        chk("ren", 32'(ren_s), 32'(v.rd && !v.wr));
      end
      if (wen_s) begin
        wcnt++;
        wcyc = c;
      end
      if (ready_s) begin
        got = 1'b1;
        e = sb.pop_front();
        chk("ready_cycle", 32'(c), 32'(e.cyc));
        chk("read_data", mrd_s, e.rdata);
        chk("error", 32'(err_s), 32'(e.err));
        chk("freeze_done", 32'(freeze_s), 32'd0);
        chk("maddr_done", maddr_s, 32'd0);
        break;
      end else begin
        chk("freeze_access", 32'(freeze_s), 32'd1);
      end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    chk("wen_count", 32'(wcnt), (v.exp_wcyc != 0) ? 32'd1 : 32'd0);
    if (v.exp_wcyc != 0) chk("wen_cycle", 32'(wcyc), 32'(v.exp_wcyc));
    if (v.chk_idx >= 0) begin
      chk("mem_word", (v.sel == 1) ? mem3[v.chk_idx] : mem1[v.chk_idx], v.chk_val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n1, n2;
    bit   ok;
    exp_t e;

    for (int i = 0; i < 256; i++) begin
      mem1[i] <= 32'd0;
      mem3[i] <= 32'd0;
    end
    mem1[0]   <= 32'h0000_0011;
    mem1[100] <= 32'd255;
    mem1[102] <= 32'h1234_5678;
    mem3[3]   <= 32'h0000_3333;

    //             sel rd    wr    addr   wdata         exp_addr rdata         cyc err   wcyc idx  val
    vecs[0] = '{0, 1'b1, 1'b0, 32'd1424, 32'd0,         32'd100, 32'd255,      2, 1'b0, 0, -1, 32'd0};
    vecs[1] = '{1, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF,  32'd1,   32'd0,        4, 1'b0, 3,  1, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 1'b0, 32'd1028, 32'd0,         32'd1,   32'hDEADBEEF, 4, 1'b0, 0, -1, 32'd0};
    vecs[3] = '{1, 1'b1, 1'b1, 32'd1032, 32'd7,         32'd2,   32'hDEADBEEF, 4, 1'b0, 3,  2, 32'd7};
`ifdef MEM_RANGE_CHECK_EN
    vecs[4] = '{0, 1'b0, 1'b1, 32'd1020, 32'h0000_00A5, 32'd255, 32'd255,      2, 1'b1, 0, 255, 32'd0};
    vecs[6] = '{0, 1'b1, 1'b0, 32'd2048, 32'd0,         32'd0,   32'd0,        2, 1'b1, 0, -1, 32'd0};
`else
    vecs[4] = '{0, 1'b0, 1'b1, 32'd1020, 32'h0000_00A5, 32'd255, 32'd255,      2, 1'b0, 1, 255, 32'h0000_00A5};
    vecs[6] = '{0, 1'b1, 1'b0, 32'd2048, 32'd0,         32'd0,   32'h11,       2, 1'b0, 0, -1, 32'd0};
`endif
    vecs[5] = '{0, 1'b1, 1'b0, 32'd1027, 32'd0,         32'd0,   32'h11,       2, 1'b0, 0, -1, 32'd0};
    vecs[7] = '{0, 1'b1, 1'b0, 32'd1424, 32'd0,         32'd100, 32'd255,      2, 1'b0, 0, -1, 32'd0};

    rst1 = 1'b0; rst3 = 1'b0;
    sel = 1; drive(1'b0, 1'b0, 32'd0, 32'd0);
    sel = 0; drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    sel = 0; check_quiet("rst1");
    sel = 1; check_quiet("rst3");
    rst1 = 1'b1; rst3 = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Back-to-back reads: second accepted in the IDLE cycle after DONE,
    // so the Ready pulses are WAIT_CYCLES+1 idle cycles apart (3 cycles edge to edge).
    sel = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd1424, 32'd0);
    sb.push_back('{rdata: 32'd255, cyc: 2, err: 1'b0});
    wait_ready(n1, ok);
    e = sb.pop_front();
    chk("b2b_first_cycle", 32'(n1), 32'(e.cyc));
    chk("b2b_first_data", mrd_s, e.rdata);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd1432, 32'd0);
    sb.push_back('{rdata: 32'h1234_5678, cyc: 2, err: 1'b0});
    #1 chk("b2b_freeze", 32'(freeze_s), 32'd1);
    wait_ready(n2, ok);
    e = sb.pop_front();
    chk("b2b_gap", 32'(1 + n2), 32'd3);
    chk("b2b_second_data", mrd_s, e.rdata);

    // Reset in the 2nd ACCESS cycle of a WAIT_CYCLES=3 write
    sel = 1;
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd1036, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    #1 check_quiet("midrst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_ready", 32'(ready_s), 32'd0);
    end
    chk("midrst_word", mem3[3], 32'h0000_3333);
    rst3 = 1'b1;
    drive(1'b1, 1'b0, 32'd1028, 32'd0);
    sb.push_back('{rdata: 32'hDEADBEEF, cyc: 4, err: 1'b0});
    wait_ready(n1, ok);
    e = sb.pop_front();
    chk("post_rst_cycle", 32'(n1), 32'(e.cyc));
    chk("post_rst_data", mrd_s, e.rdata);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of ACCESS-state cycles per transaction; legal range 1..15.
REQ-002 Parameter ADDR_BASE, default 1024, byte address mapped to memory word 0.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 MEM_R_EN  in  1  pipeline read request.
REQ-006 MEM_W_EN  in  1  pipeline write request.
REQ-007 ALU_Result  in  32  pipeline byte address.
REQ-008 Val_Rm  in  32  pipeline store data.
REQ-009 Mem_Read_Data  out  32  registered load result to pipeline.
REQ-010 Ready  out  1  one-cycle completion pulse.
REQ-011 Freeze  out  1  pipeline stall request.
REQ-012 Error  out  1  out-of-range access flag, held until next request.
REQ-013 Mem_Address  out  32  word index to data memory, bits [31:8] zero.
REQ-014 Mem_Write_data  out  32  store data to data memory.
REQ-015 Mem_R_EN_o  out  1  memory read enable.
REQ-016 Mem_W_EN_o  out  1  memory write enable; memory writes on the rising edge while high.
REQ-017 Mem_Data  in  32  combinational read data from data memory.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-019 IDLE with MEM_R_EN or MEM_W_EN high: SHALL latch the address, the data and the operation type, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-020 ACCESS: SHALL decrement the counter each cycle and go to DONE when the counter is 0 (exactly WAIT_CYCLES cycles in ACCESS).
REQ-021 DONE: Ready SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE unconditionally.
REQ-022 Freeze SHALL equal (IDLE and request) or ACCESS, combinationally; Freeze SHALL be 0 in DONE.
REQ-023 Word index SHALL be ((latched address - ADDR_BASE) >> 2)[7:0]; byte bits [1:0] are ignored.
REQ-024 Mem_Address, Mem_Write_data and Mem_R_EN_o SHALL be driven from latched values throughout ACCESS; Mem_R_EN_o SHALL be high only for reads.
REQ-025 Mem_W_EN_o SHALL be high only in the final ACCESS cycle of a write, giving exactly one memory write per transaction.
REQ-026 For reads, Mem_Data SHALL be registered into Mem_Read_Data at the end of the final ACCESS cycle; the value SHALL be valid while Ready is high and held until the next read completes.
REQ-027 For writes, Mem_Read_Data SHALL be unchanged.
REQ-028 MEM_R_EN and MEM_W_EN both high SHALL be treated as a write; Mem_Read_Data SHALL be unchanged.
REQ-029 Request inputs SHALL be ignored outside IDLE; back-to-back requests SHALL be accepted in the IDLE cycle directly after DONE.
REQ-030 Outside ACCESS, Mem_R_EN_o and Mem_W_EN_o SHALL be 0 and Mem_Address SHALL be 0.

Reset
REQ-031 rst low SHALL immediately force IDLE; Mem_Read_Data, the counter and Error SHALL clear to 0, and Mem_R_EN_o, Mem_W_EN_o and Ready SHALL go to 0.
REQ-032 Reset mid-ACCESS SHALL abort the transaction with no memory write and no Ready pulse.
REQ-033 After rst rises, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-034 With MEM_RANGE_CHECK_EN defined: an address below ADDR_BASE or at or above ADDR_BASE+1024 SHALL set Error in DONE, suppress Mem_W_EN_o, and load 0 into Mem_Read_Data for reads; the transaction timing SHALL be unchanged.
REQ-035 Without MEM_RANGE_CHECK_EN: Error SHALL be tied 0 and the index SHALL wrap modulo 256 per REQ-023.

Verification
REQ-036 WAIT_CYCLES=1, memory word 100=255, read at ALU_Result=1424 -> Mem_Address=100, Ready in cycle 2, Mem_Read_Data=255, Freeze high in cycles 0-1.
REQ-037 WAIT_CYCLES=3, write 0xDEADBEEF to 1028 -> Mem_W_EN_o high only in cycle 3, word 1 = 0xDEADBEEF, Ready in cycle 4, a later read of 1028 returns 0xDEADBEEF.
REQ-038 Both enables high at 1032 with data 7 -> word 2 = 7, Mem_Read_Data unchanged.
REQ-039 rst low in the 2nd ACCESS cycle of a write with WAIT_CYCLES=3 -> target word unmodified, no Ready, all outputs 0.
REQ-040 MEM_RANGE_CHECK_EN defined, write at 1020 -> Error=1, no memory write, Ready at the normal cycle; without the macro -> word 255 written, Error=0.
REQ-041 Back-to-back reads of 1424 then 1432 -> second accepted in the cycle after the first DONE, Ready pulses separated by WAIT_CYCLES+1 cycles.
